// File: rtl/deser_pkg.sv
// Shared types for the bit-serial word deserializer.
// The PARITY state is only reached when DESER_PARITY_EN is defined.
package deser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } deser_state_t;

  localparam int DESER_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/deser_out_buf.sv
// One-entry valid/ready holding register for completed words.
// A word arriving while the entry is full and not being drained is dropped and flagged.
module deser_out_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             load_perr_i,
  input  logic             out_ready_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_perr_o,
  output logic             overrun_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             perr_q, perr_d;
  logic             overrun_q, overrun_d;
  logic             can_load;

  // Handshake: a word leaves when out_valid_o && out_ready_i at a posedge; a
  // drain and a load in the same cycle keep out_valid_o high with the new word.
  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    perr_d    = perr_q;
    overrun_d = 1'b0;
    can_load  = !valid_q || out_ready_i;
    if (load_i && can_load) begin
      valid_d = 1'b1;
      data_d  = load_data_i;
      perr_d  = load_perr_i;
    end else begin
      if (valid_q && out_ready_i) valid_d = 1'b0;
      if (load_i) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      perr_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      perr_q    <= perr_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_perr_o  = perr_q;
  assign overrun_o   = overrun_q;

endmodule

// File: rtl/serial_word_deserializer.sv
// Collects start-aligned 1-bit samples into WIDTH-bit words behind a one-entry output buffer.
// Define DESER_PARITY_EN to expect an even-parity bit after each word's data bits.
module serial_word_deserializer
  import deser_pkg::*;
#(
  parameter int WIDTH     = DESER_DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin_valid,
  input  logic             sin_data,
  input  logic             sin_start,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_perr,
  output logic             overrun,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  deser_state_t     state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] done_data_q, done_data_d;
  logic             done_perr_q, done_perr_d;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] first;

  always_comb begin
    shifted = MSB_FIRST ? {shift_q[WIDTH-2:0], sin_data} : {sin_data, shift_q[WIDTH-1:1]};
    first   = MSB_FIRST ? {{(WIDTH-1){1'b0}}, sin_data} : {sin_data, {(WIDTH-1){1'b0}}};
  end

  // A start strobe always wins, even on what would have been a completing bit.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    done_d      = 1'b0;
    done_data_d = done_data_q;
    done_perr_d = done_perr_q;
    if (sin_valid) begin
      if (sin_start) begin
        state_d = SHIFT;
        cnt_d   = CW'(1);
        shift_d = first;
      end else begin
        case (state_q)
          IDLE: ;
          SHIFT: begin
            shift_d = shifted;
            if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef DESER_PARITY_EN
              cnt_d   = CW'(WIDTH);
              state_d = PARITY;
`else
              cnt_d       = '0;
              done_d      = 1'b1;
              done_data_d = shifted;
              done_perr_d = 1'b0;
`endif
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
`ifdef DESER_PARITY_EN
          PARITY: begin
            cnt_d       = '0;
            state_d     = SHIFT;
            done_d      = 1'b1;
            done_data_d = shift_q;
            done_perr_d = ^{shift_q, sin_data};
          end
`endif
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // The completed word is staged one cycle so the shift register can start the next word at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      done_q      <= 1'b0;
      done_data_q <= '0;
      done_perr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      done_q      <= done_d;
      done_data_q <= done_data_d;
      done_perr_q <= done_perr_d;
    end
  end

  assign busy = (state_q != IDLE);

  deser_out_buf #(
    .WIDTH(WIDTH)
  ) u_out_buf (
    .clk         (clk),
    .rst         (rst),
    .load_i      (done_q),
    .load_data_i (done_data_q),
    .load_perr_i (done_perr_q),
    .out_ready_i (out_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_perr_o  (out_perr),
    .overrun_o   (overrun)
  );

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Bench for serial_word_deserializer: an MSB-first and an LSB-first instance share one stimulus stream.
// Expected words go into queues; a monitor pops them on every output handshake.
module tb_serial_word_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       sin_valid, sin_data, sin_start, out_ready;
  logic       out_valid, out_perr, overrun, busy;
  logic [7:0] out_data;
  logic       lsb_valid, lsb_perr, lsb_overrun, lsb_busy;
  logic [7:0] lsb_data;

  logic [8:0] exp_q[$];
  logic [8:0] exp_lsb_q[$];
  logic [8:0] mon_e, mon_l;
  int         n_checks = 0;
  int         n_pass   = 0;

  always #5 clk = ~clk;

  serial_word_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut (
    .clk(clk), .rst(rst), .sin_valid(sin_valid), .sin_data(sin_data), .sin_start(sin_start),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_perr(out_perr),
    .overrun(overrun), .busy(busy)
  );

  serial_word_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .sin_valid(sin_valid), .sin_data(sin_data), .sin_start(sin_start),
    .out_valid(lsb_valid), .out_ready(out_ready), .out_data(lsb_data), .out_perr(lsb_perr),
    .overrun(lsb_overrun), .busy(lsb_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] bitrev(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic send_bit(input logic b, input logic st);
    @(negedge clk);
    sin_valid = 1'b1;
    sin_data  = b;
    sin_start = st;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    sin_valid = 1'b0;
    sin_data  = 1'b0;
    sin_start = 1'b0;
  endtask

  // Bits go out first-to-last as data[7]..data[0]; bad_par flips the parity bit when present.
  task automatic send_word(input logic [7:0] data, input logic push, input logic bad_par);
    logic perr;
    for (int i = 0; i < 8; i++) send_bit(data[7-i], (i == 0));
`ifdef DESER_PARITY_EN
    send_bit((^data) ^ bad_par, 1'b0);
    perr = bad_par;
`else
    perr = 1'b0;
`endif
    if (push) begin
      exp_q.push_back({perr, data});
      exp_lsb_q.push_back({perr, bitrev(data)});
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_word", {23'd0, out_perr, out_data}, 32'hdead);
      else begin
        mon_e = exp_q.pop_front();
        check("word_msb", {23'd0, out_perr, out_data}, {23'd0, mon_e});
      end
    end
    if (!rst && lsb_valid && out_ready) begin
      if (exp_lsb_q.size() == 0) check("unexpected_word_lsb", {23'd0, lsb_perr, lsb_data}, 32'hdead);
      else begin
        mon_l = exp_lsb_q.pop_front();
        check("word_lsb", {23'd0, lsb_perr, lsb_data}, {23'd0, mon_l});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; sin_valid = 1'b0; sin_data = 1'b0; sin_start = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_out_perr", {31'd0, out_perr}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    idle_cycle();

    // Basic word and output latency
    send_word(8'hA5, 1'b1, 1'b0);
    idle_cycle();
    check("lat_not_yet", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("lat_valid", {31'd0, out_valid}, 32'd1);
    check("basic_data", {24'd0, out_data}, 32'h0000_00A5);
    check("basic_overrun", {31'd0, overrun}, 32'd0);
    check("basic_busy", {31'd0, busy}, 32'd1);
    repeat (2) idle_cycle();

    // Bit order: C1 sent MSB-first lands reversed in the LSB-first instance
    send_word(8'hC1, 1'b1, 1'b0);
    idle_cycle();
    @(negedge clk);
    check("order_lsb_c1", {24'd0, lsb_data}, 32'h0000_0083);
    check("order_msb_c1", {24'd0, out_data}, 32'h0000_00C1);
    repeat (2) idle_cycle();

    // Backpressure: second word dropped with a one-cycle overrun
    out_ready = 1'b0;
    send_word(8'h3C, 1'b1, 1'b0);
    send_word(8'h5A, 1'b0, 1'b0);
    idle_cycle();
    check("ovr_early", {31'd0, overrun}, 32'd0);
    @(negedge clk);
    check("ovr_pulse", {31'd0, overrun}, 32'd1);
    check("ovr_pulse_lsb", {31'd0, lsb_overrun}, 32'd1);
    check("ovr_held_data", {24'd0, out_data}, 32'h0000_003C);
    check("ovr_held_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    check("ovr_one_cycle", {31'd0, overrun}, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("drain_valid_low", {31'd0, out_valid}, 32'd0);

    // Same-cycle drain and load
    out_ready = 1'b0;
    send_word(8'h11, 1'b1, 1'b0);
    repeat (3) idle_cycle();
    check("buf_11_valid", {31'd0, out_valid}, 32'd1);
    send_word(8'h22, 1'b1, 1'b0);
    idle_cycle();
    out_ready = 1'b1;
    @(negedge clk);
    check("swap_valid", {31'd0, out_valid}, 32'd1);
    check("swap_data", {24'd0, out_data}, 32'h0000_0022);
    check("swap_overrun", {31'd0, overrun}, 32'd0);
    repeat (2) idle_cycle();

    // Resync: partial words abandoned by a new start
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_word(8'hF0, 1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b0);
    send_word(8'h96, 1'b1, 1'b0);
    repeat (4) idle_cycle();

    // Reset mid-word with a word buffered
    out_ready = 1'b0;
    send_word(8'h77, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    idle_cycle();
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b0);
    repeat (3) idle_cycle();
    check("idle_ignore_busy", {31'd0, busy}, 32'd0);
    check("idle_ignore_valid", {31'd0, out_valid}, 32'd0);

`ifdef DESER_PARITY_EN
    send_word(8'hA5, 1'b1, 1'b0);
    send_word(8'hA5, 1'b1, 1'b1);
    repeat (3) idle_cycle();
`endif

    for (int i = 0; i < 50 && (exp_q.size() != 0 || exp_lsb_q.size() != 0); i++) @(negedge clk);
    check("queue_empty_msb", exp_q.size(), 32'd0);
    check("queue_empty_lsb", exp_lsb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
